// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the hash-state RAM arbiter.
package mem_arb_pkg;

    localparam int N_REQ_MAX  = 8;
    localparam int IDX_W      = 3;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        WAIT_INIT,
        IDLE,
        ISSUE,
        READ_WAIT
    } arb_state_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: the first requester after LAST, wrapping modulo N_REQ, wins.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = 3
)(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    // Walk from the farthest candidate back to the nearest so that the nearest one is left in win_o.
    always_comb begin
        int cand;
        cand  = 0;
        win_o = '0;
        any_o = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = (int'(last_i) + off) % N_REQ;
            if (req_i[cand]) begin
                win_o = IDX_W'(cand);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising single-beat reads and writes onto the hash-state RAM.
// state     | meaning
// WAIT_INIT | RAM not ready; all requests held off
// IDLE      | arbitrate among the REQ lines
// ISSUE     | drive the RAM port for the winner and pulse its GNT
// READ_WAIT | RAM read data arrives; it is captured and RVALID follows
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      INIT_COMPLETE,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ-1:0]          WE,
    input  logic [N_REQ*ADDR_W-1:0]   ADDR,
    input  logic [N_REQ*DATA_W-1:0]   WDATA,
    output logic [N_REQ-1:0]          GNT,
    output logic [N_REQ-1:0]          RVALID,
    output logic [DATA_W-1:0]         RDATA,
    output logic                      BUSY,
    output logic                      MEM_EN,
    output logic                      MEM_WE,
    output logic [ADDR_W-1:0]         MEM_ADDR,
    output logic [DATA_W-1:0]         MEM_WDATA,
    input  logic [DATA_W-1:0]         MEM_RDATA
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]  win;
    logic              any_req;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i  (REQ),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (any_req)
    );

    // Next state and next output values; the MEM_* address/data registers double as the request latches.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        idx_d       = idx_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            WAIT_INIT: begin
                if (INIT_COMPLETE) state_d = IDLE;
            end
            IDLE: begin
                if (!INIT_COMPLETE) begin
                    state_d = WAIT_INIT;
                end else if (any_req) begin
                    state_d     = ISSUE;
                    last_d      = win;
                    idx_d       = win;
                    gnt_d       = ONE << win;
                    mem_en_d    = 1'b1;
                    mem_we_d    = WE[win];
                    mem_addr_d  = ADDR[win*ADDR_W +: ADDR_W];
                    mem_wdata_d = WDATA[win*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                state_d = mem_we_q ? IDLE : READ_WAIT;
            end
            READ_WAIT: begin
                state_d  = IDLE;
                rdata_d  = MEM_RDATA;
                rvalid_d = ONE << idx_q;
            end
            default: state_d = WAIT_INIT;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, pointer and output registers; reset drops any in-flight transaction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= WAIT_INIT;
            last_q      <= LAST_RST;
            idx_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign GNT       = gnt_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign BUSY      = busy_q;
    assign MEM_EN    = mem_en_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM and a reference arbitration model.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        INIT_COMPLETE;
    logic [2:0]  REQ;
    logic [2:0]  WE;
    logic [23:0] ADDR;
    logic [95:0] WDATA;
    logic [2:0]  GNT;
    logic [2:0]  RVALID;
    logic [31:0] RDATA;
    logic        BUSY;
    logic        MEM_EN;
    logic        MEM_WE;
    logic [7:0]  MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    logic [31:0] ram [256] = '{default: 32'h0};
    logic [31:0] rd_q = 32'h0;

    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [7:0]  addr_v [3];
    logic [31:0] wd_v [3];

    logic [31:0] ref_mem [256];
    int          ref_last;
    int          gseq [$];
    int          n_checks;
    int          n_fail;

    mem_arbiter dut (
        .CLK           (CLK),
        .RST           (RST),
        .INIT_COMPLETE (INIT_COMPLETE),
        .REQ           (REQ),
        .WE            (WE),
        .ADDR          (ADDR),
        .WDATA         (WDATA),
        .GNT           (GNT),
        .RVALID        (RVALID),
        .RDATA         (RDATA),
        .BUSY          (BUSY),
        .MEM_EN        (MEM_EN),
        .MEM_WE        (MEM_WE),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_WDATA     (MEM_WDATA),
        .MEM_RDATA     (MEM_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port synchronous RAM: read data appears one cycle after the enable.
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
            else        rd_q <= ram[MEM_ADDR];
        end
    end
    assign MEM_RDATA = rd_q;

    task automatic drive();
        REQ   = req_v;
        WE    = we_v;
        ADDR  = {addr_v[2], addr_v[1], addr_v[0]};
        WDATA = {wd_v[2], wd_v[1], wd_v[0]};
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        req_v = 3'b000;
        we_v  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_v[i] = 8'h00;
            wd_v[i]   = 32'h0;
        end
        drive();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        INIT_COMPLETE = 1'b0;
        idle_inputs();
        step();
        step();
        n_checks++; if (GNT !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", GNT); end
        n_checks++; if (RVALID !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 000", RVALID); end
        n_checks++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", BUSY); end
        n_checks++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", MEM_EN); end
        n_checks++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", MEM_WE); end
        n_checks++; if (MEM_ADDR !== 8'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", MEM_ADDR); end
        n_checks++; if (MEM_WDATA !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", MEM_WDATA); end
        ref_last = 2;
    endtask

    task automatic test_init_hold();
        RST = 1'b0;
        req_v = 3'b111;
        drive();
        for (int c = 0; c < 50; c++) begin
            step();
            n_checks++; if (GNT !== 3'b000) begin n_fail++; $display("FAIL init_hold_gnt c=%0d: got %b want 000", c, GNT); end
            n_checks++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL init_hold_mem_en c=%0d: got %b want 0", c, MEM_EN); end
            n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL init_hold_busy c=%0d: got %b want 1", c, BUSY); end
        end
        INIT_COMPLETE = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            if (GNT !== 3'b000) break;
        end
        n_checks++; if (GNT !== 3'b001) begin n_fail++; $display("FAIL init_first_gnt: got %b want 001", GNT); end
        idle_inputs();
        repeat (4) step();
        ref_last = 0;
    endtask

    task automatic test_write_read();
        req_v = 3'b010; we_v = 3'b010; addr_v[1] = 8'h10; wd_v[1] = 32'hDEADBEEF;
        drive();
        step();
        n_checks++; if (GNT !== 3'b010) begin n_fail++; $display("FAIL wr_gnt: got %b want 010", GNT); end
        n_checks++; if (MEM_EN !== 1'b1) begin n_fail++; $display("FAIL wr_mem_en: got %b want 1", MEM_EN); end
        n_checks++; if (MEM_WE !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we: got %b want 1", MEM_WE); end
        n_checks++; if (MEM_ADDR !== 8'h10) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 10", MEM_ADDR); end
        n_checks++; if (MEM_WDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem_wdata: got %h want deadbeef", MEM_WDATA); end
        req_v = 3'b000; drive();
        step();
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL wr_back_idle: got busy %b want 0", BUSY); end
        req_v = 3'b010; we_v = 3'b000; drive();
        step();
        n_checks++; if (GNT !== 3'b010) begin n_fail++; $display("FAIL rd_gnt: got %b want 010", GNT); end
        n_checks++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we: got %b want 0", MEM_WE); end
        req_v = 3'b000; drive();
        step();
        n_checks++; if (RVALID !== 3'b000) begin n_fail++; $display("FAIL rd_early_rvalid: got %b want 000", RVALID); end
        n_checks++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL rd_wait_mem_en: got %b want 0", MEM_EN); end
        step();
        n_checks++; if (RVALID !== 3'b010) begin n_fail++; $display("FAIL rd_rvalid: got %b want 010", RVALID); end
        n_checks++; if (RDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", RDATA); end
        step();
        n_checks++; if (RVALID !== 3'b000) begin n_fail++; $display("FAIL rd_rvalid_pulse: got %b want 000", RVALID); end
        idle_inputs();
        ref_last = 1;
    endtask

    task automatic test_withdraw();
        req_v = 3'b001; addr_v[0] = 8'h10; drive();
        step();
        n_checks++; if (GNT !== 3'b001) begin n_fail++; $display("FAIL wd_gnt0: got %b want 001", GNT); end
        req_v = 3'b100; drive();
        step();
        req_v = 3'b000; drive();
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++; if (GNT !== 3'b000) begin n_fail++; $display("FAIL wd_gnt c=%0d: got %b want 000", c, GNT); end
            n_checks++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL wd_mem_en c=%0d: got %b want 0", c, MEM_EN); end
        end
        idle_inputs();
        ref_last = 0;
    endtask

    // Reference: a grant appears one cycle after a sampling edge at which the port was free;
    // the winner is the first requester after the previous winner, counting upward modulo 3.
    task automatic run_traffic(input int cycles, input logic [2:0] mask, input bit rnd);
        logic [2:0]  pend, dreq, exp_g, exp_rv;
        logic [31:0] rv_data;
        int earliest, rv_time, rv_idx, w;
        pend = 3'b000; earliest = 1; rv_time = -1; rv_idx = 0; rv_data = 32'h0;
        gseq.delete();
        for (int t = 0; t < cycles + 4; t++) begin
            if (t >= cycles) begin
                pend = 3'b000;
            end else if (!rnd) begin
                pend = mask;
                for (int i = 0; i < 3; i++) begin
                    we_v[i] = 1'b0; addr_v[i] = 8'h20 + 8'(i); wd_v[i] = 32'h1000 + 32'(i);
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i]   = 1'b1;
                        we_v[i]   = 1'($urandom_range(0, 1));
                        addr_v[i] = 8'h20 + 8'($urandom_range(0, 15));
                        wd_v[i]   = $urandom;
                    end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                        pend[i] = 1'b0;
                    end
                end
            end
            req_v = pend; drive();
            dreq = pend;
            step();
            exp_g = 3'b000; w = -1;
            if (t + 1 >= earliest && dreq != 3'b000) begin
                for (int off = 1; off <= 3 && w < 0; off++)
                    if (dreq[(ref_last + off) % 3]) w = (ref_last + off) % 3;
                exp_g = 3'b001 << w;
            end
            exp_rv = (t + 1 == rv_time) ? (3'b001 << rv_idx) : 3'b000;
            n_checks++; if (GNT !== exp_g) begin n_fail++; $display("FAIL traffic_gnt t=%0d: got %b want %b", t, GNT, exp_g); end
            n_checks++; if (MEM_EN !== (exp_g != 3'b000)) begin n_fail++; $display("FAIL traffic_mem_en t=%0d: got %b want %b", t, MEM_EN, exp_g != 3'b000); end
            n_checks++; if (RVALID !== exp_rv) begin n_fail++; $display("FAIL traffic_rvalid t=%0d: got %b want %b", t, RVALID, exp_rv); end
            if (exp_rv != 3'b000) begin
                n_checks++; if (RDATA !== rv_data) begin n_fail++; $display("FAIL traffic_rdata t=%0d: got %h want %h", t, RDATA, rv_data); end
            end
            if (w >= 0) begin
                n_checks++; if (MEM_WE !== we_v[w]) begin n_fail++; $display("FAIL traffic_mem_we t=%0d: got %b want %b", t, MEM_WE, we_v[w]); end
                n_checks++; if (MEM_ADDR !== addr_v[w]) begin n_fail++; $display("FAIL traffic_mem_addr t=%0d: got %h want %h", t, MEM_ADDR, addr_v[w]); end
                n_checks++; if (MEM_WDATA !== wd_v[w]) begin n_fail++; $display("FAIL traffic_mem_wdata t=%0d: got %h want %h", t, MEM_WDATA, wd_v[w]); end
                ref_last = w;
                gseq.push_back(w);
                if (we_v[w]) begin
                    ref_mem[addr_v[w]] = wd_v[w];
                    earliest = t + 3;
                end else begin
                    rv_time  = t + 3;
                    rv_idx   = w;
                    rv_data  = ref_mem[addr_v[w]];
                    earliest = t + 4;
                end
                if (rnd) pend[w] = 1'b0;
            end
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        run_traffic(30, 3'b111, 1'b0);
        n_checks++; if (gseq.size() < 9) begin n_fail++; $display("FAIL rr_count: got %0d grants want >= 9", gseq.size()); end
        if (gseq.size() > 0) begin
            n_checks++; if (gseq[0] != 1) begin n_fail++; $display("FAIL rr_first: got %0d want 1", gseq[0]); end
        end
        for (int j = 2; j < gseq.size(); j++) begin
            n_checks++;
            if (gseq[j] == gseq[j-1] || gseq[j] == gseq[j-2]) begin
                n_fail++; $display("FAIL rr_fair j=%0d: got %0d after %0d,%0d", j, gseq[j], gseq[j-2], gseq[j-1]);
            end
        end
    endtask

    task automatic test_alternate();
        run_traffic(2, 3'b001, 1'b0);
        run_traffic(24, 3'b101, 1'b0);
        n_checks++; if (gseq.size() < 6) begin n_fail++; $display("FAIL alt_count: got %0d grants want >= 6", gseq.size()); end
        if (gseq.size() > 0) begin
            n_checks++; if (gseq[0] != 2) begin n_fail++; $display("FAIL alt_first: got %0d want 2", gseq[0]); end
        end
        for (int j = 0; j < gseq.size(); j++) begin
            n_checks++; if (gseq[j] == 1) begin n_fail++; $display("FAIL alt_no_req1 j=%0d: got 1 want 0 or 2", j); end
            if (j > 0) begin
                n_checks++; if (gseq[j] == gseq[j-1]) begin n_fail++; $display("FAIL alt_alternate j=%0d: got %0d twice", j, gseq[j]); end
            end
        end
    endtask

    task automatic test_random();
        run_traffic(400, 3'b000, 1'b1);
        n_checks++; if (gseq.size() < 40) begin n_fail++; $display("FAIL rand_count: got %0d grants want >= 40", gseq.size()); end
    endtask

    task automatic test_reset_mid_read();
        req_v = 3'b001; we_v = 3'b000; addr_v[0] = 8'h10; drive();
        step();
        req_v = 3'b000; drive();
        step();
        step();
        n_checks++; if (RDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rst_pre_rdata: got %h want deadbeef", RDATA); end
        step();
        req_v = 3'b010; addr_v[1] = 8'h10; drive();
        step();
        n_checks++; if (GNT !== 3'b010) begin n_fail++; $display("FAIL rst_pre_gnt: got %b want 010", GNT); end
        req_v = 3'b000; drive();
        step();
        RST = 1'b1;
        #1;
        n_checks++; if (GNT !== 3'b000) begin n_fail++; $display("FAIL rst_async_gnt: got %b want 000", GNT); end
        n_checks++; if (RVALID !== 3'b000) begin n_fail++; $display("FAIL rst_async_rvalid: got %b want 000", RVALID); end
        n_checks++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL rst_async_rdata: got %h want 0", RDATA); end
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_async_busy: got %b want 1", BUSY); end
        n_checks++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL rst_async_mem_en: got %b want 0", MEM_EN); end
        n_checks++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL rst_async_mem_we: got %b want 0", MEM_WE); end
        n_checks++; if (MEM_ADDR !== 8'h0) begin n_fail++; $display("FAIL rst_async_mem_addr: got %h want 0", MEM_ADDR); end
        n_checks++; if (MEM_WDATA !== 32'h0) begin n_fail++; $display("FAIL rst_async_mem_wdata: got %h want 0", MEM_WDATA); end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (RVALID !== 3'b000) begin n_fail++; $display("FAIL rst_hold_rvalid c=%0d: got %b want 000", c, RVALID); end
        end
        RST = 1'b0;
        req_v = 3'b111; drive();
        for (int c = 0; c < 3; c++) begin
            step();
            if (GNT !== 3'b000) break;
        end
        n_checks++; if (GNT !== 3'b001) begin n_fail++; $display("FAIL rst_first_gnt: got %b want 001", GNT); end
        idle_inputs();
        repeat (4) step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ref_last = 2;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        RST = 1'b1;
        INIT_COMPLETE = 1'b0;
        idle_inputs();
        test_reset();
        test_init_hold();
        test_write_read();
        test_withdraw();
        test_round_robin();
        test_alternate();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing the single-port hash-state RAM behind the memory manager between up to N_REQ requesters (message loader, compression round engine, digest readout). It holds all access off until the memory manager reports INIT_COMPLETE. It then serialises single-beat read and write transactions onto the RAM port and routes read data back to the winning requester.

## Interface
- N_REQ, 3: number of requesters, 2..8
- ADDR_W, 8: RAM address width
- DATA_W, 32: RAM word width (one SHA-256 word)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- INIT_COMPLETE  in  1  from memory manager; RAM usable while high
- REQ  in  N_REQ  per-requester request, held until GNT
- WE  in  N_REQ  per-requester write flag (1 = write, 0 = read), valid with REQ
- ADDR  in  N_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- WDATA  in  N_REQ*DATA_W  packed write data, same packing
- GNT  out  N_REQ  one-hot, one-cycle pulse: request accepted
- RVALID  out  N_REQ  one-hot, one-cycle pulse: RDATA holds read result
- RDATA  out  DATA_W  shared read data, valid only with RVALID
- BUSY  out  1  high in any state other than IDLE
- MEM_EN, MEM_WE  out  1 each  RAM enable and write strobe
- MEM_ADDR  out  ADDR_W  RAM address
- MEM_WDATA  out  DATA_W  RAM write data
- MEM_RDATA  in  DATA_W  RAM read data, valid one cycle after a read MEM_EN cycle

## Operation
- FSM states:
  - WAIT_INIT
    - Entered on reset.
    - Exits to IDLE when INIT_COMPLETE is sampled high.
  - IDLE
    - If INIT_COMPLETE is low, go to WAIT_INIT.
    - Else, if any REQ is high, register the winner's index, WE, ADDR and WDATA, then go to ISSUE.
    - Else stay.
  - ISSUE
    - MEM_EN=1, MEM_WE=latched WE, MEM_ADDR/MEM_WDATA=latched values.
    - GNT[idx]=1.
    - Next state is READ_WAIT for a read, IDLE for a write.
  - READ_WAIT
    - RDATA is loaded from MEM_RDATA at the end of this cycle.
    - RVALID[idx] pulses in the following cycle, which is IDLE.
- Round-robin pointer LAST:
  - Reset to N_REQ-1, so requester 0 wins first.
  - Search order is LAST+1, LAST+2, … modulo N_REQ.
  - LAST is updated to the winner on entry to ISSUE.
- REQ is sampled only in IDLE.
  - A requester may drop REQ before GNT (withdrawal); nothing is issued for it.
  - A requester must not change WE/ADDR/WDATA while REQ is high and GNT has not been seen.
- At most one outstanding transaction; no overlap of arbitration with READ_WAIT.
- INIT_COMPLETE falling in ISSUE or READ_WAIT: the transaction completes, including RVALID, then the FSM enters WAIT_INIT from IDLE.
- Reset mid-transaction:
  - All outputs return to reset values immediately.
  - The pending RVALID is never emitted.
  - LAST returns to N_REQ-1.

## Timing
- Reset values:
  - GNT=0, RVALID=0, RDATA=0, BUSY=1 (WAIT_INIT)
  - MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0
- All outputs are registered; there is no combinational path from REQ to GNT or MEM_*.
- Read, with REQ sampled high at edge k in IDLE:
  - cycle k+1: ISSUE, GNT and MEM_EN high
  - cycle k+2: READ_WAIT
  - cycle k+3: RVALID with RDATA
  - Earliest next arbitration is edge k+3.
- Write, with REQ sampled at edge k:
  - cycle k+1: ISSUE
  - Next arbitration at edge k+2.
  - Sustained write throughput is one write per 2 cycles.
- MEM_EN is low in WAIT_INIT, IDLE and READ_WAIT.

## Structure
- Package mem_arb_pkg:
  - state enum (WAIT_INIT, IDLE, ISSUE, READ_WAIT)
  - default ADDR_W/DATA_W constants
  - N_REQ upper bound 8
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: REQ vector and LAST.
  - Outputs: winner index and any-request flag.
  - Modulo wrap is handled inside.
- The top level holds the FSM, pointer, latches and output registers.

## Test plan
- Reset then INIT_COMPLETE held low for 50 cycles with REQ=3'b111 -> no GNT, MEM_EN stays 0, BUSY=1. INIT_COMPLETE rises -> first GNT is 3'b001 within 2 cycles.
- Requester 1 writes 0xDEADBEEF to address 0x10, then reads 0x10 -> write ISSUE shows MEM_WE=1 with MEM_ADDR=0x10. RVALID=3'b010 with RDATA=0xDEADBEEF exactly 3 cycles after the read REQ is sampled.
- REQ=3'b111 held, all reads -> GNT order 001, 010, 100, 001, …; no requester is granted twice before the other two.
- REQ=3'b101 continuous after LAST=0 -> grants alternate 100, 001; requester 1 is never granted.
- Requester 2 asserts REQ then drops it one cycle before arbitration -> no GNT and no MEM_EN for index 2.
- RST asserted during READ_WAIT -> RVALID never pulses and all outputs return to reset values asynchronously. After release and INIT_COMPLETE=1, requester 0 wins first.
